// File: rtl/exec_ctrl_issue_pkg.sv
// Shared types for the decode-to-execute issue controller: FSM states and
// the packed control bundle that travels from D into the E-stage register.
package exec_ctrl_issue_pkg;

    // Widest register address the bundle can carry; narrower RAW values are
    // zero-extended into it so the bundle type does not depend on RAW.
    localparam int WA_MAX = 16;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        LDSTALL = 2'd2,
        MEMWAIT = 2'd3
    } issue_state_t;

    typedef struct packed {
        logic              branch;
        logic              mem_write;
        logic              reg_write;
        logic              flag_w;
        logic              no_write;
        logic              mem_to_reg;
        logic [1:0]        cond;
        logic [WA_MAX-1:0] wa3;
        logic              valid;
    } ctrl_bundle_t;

    // A bubble is the all-zero bundle: no side effects, not valid.
    localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/exec_ctrl_issue_ctrl_pipe_reg.sv
// E-stage control register: holds when en is low, loads a bubble on flush.
module ctrl_pipe_reg
    import exec_ctrl_issue_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  ctrl_bundle_t d,
    output ctrl_bundle_t q
);

    // Capture the D bundle (or a bubble) when enabled; clear on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= BUBBLE;
        end else if (en) begin
            q <= flush ? BUBBLE : d;
        end
    end

endmodule

// File: rtl/exec_ctrl_issue.sv
// Issue control between decode and execute: registers the decoded control
// bundle into E, inserting bubbles for branch flushes and load-use hazards,
// freezing on a busy memory stage, and counting branch flushes.
module exec_ctrl_issue
    import exec_ctrl_issue_pkg::*;
#(
    parameter int RAW  = 4,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ValidD,
    input  logic            BranchD,
    input  logic            MemWriteD,
    input  logic            RegWriteD,
    input  logic            FlagWD,
    input  logic            NoWriteD,
    input  logic            MemtoRegD,
    input  logic [1:0]      CondD,
    input  logic [RAW-1:0]  RA1D,
    input  logic [RAW-1:0]  RA2D,
    input  logic [RAW-1:0]  WA3D,
    input  logic            PCSrcE,
    input  logic            MemBusy,
    output logic            BranchE,
    output logic            MemWriteE,
    output logic            RegWriteE,
    output logic            FlagWE,
    output logic            NoWriteE,
    output logic            MemtoRegE,
    output logic [1:0]      CondE,
    output logic [RAW-1:0]  WA3E,
    output logic            ValidE,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD,
    output logic [CNTW-1:0] FlushCnt
);

    issue_state_t  state;
    ctrl_bundle_t  d_bundle;
    ctrl_bundle_t  e_bundle;
    logic [CNTW-1:0] flush_cnt;
    logic active;
    logic load_use;
    logic hold;
    logic take_branch;
    logic stall_load;
    logic pipe_en;
    logic pipe_flush;

    // Gather the decoded control bits into one bundle.
    always_comb begin
        d_bundle            = BUBBLE;
        d_bundle.branch     = BranchD;
        d_bundle.mem_write  = MemWriteD;
        d_bundle.reg_write  = RegWriteD;
        d_bundle.flag_w     = FlagWD;
        d_bundle.no_write   = NoWriteD;
        d_bundle.mem_to_reg = MemtoRegD;
        d_bundle.cond       = CondD;
        d_bundle.wa3        = WA_MAX'(WA3D);
        d_bundle.valid      = ValidD;
    end

    // Hazard resolution in priority order: memory busy, taken branch, load-use.
    always_comb begin
        active      = (state != BOOT);
        load_use    = e_bundle.mem_to_reg & e_bundle.valid & ValidD &
                      ((e_bundle.wa3 == WA_MAX'(RA1D)) | (e_bundle.wa3 == WA_MAX'(RA2D)));
        hold        = active & MemBusy;
        take_branch = active & ~MemBusy & PCSrcE;
        stall_load  = active & ~MemBusy & ~PCSrcE & load_use;
        StallF      = hold | stall_load;
        StallD      = hold | stall_load;
        FlushD      = ~active | take_branch;
        pipe_en     = ~hold;
        pipe_flush  = ~active | take_branch | stall_load | ~ValidD;
    end

    ctrl_pipe_reg u_e_reg (
        .clk   (clk),
        .rst   (rst),
        .en    (pipe_en),
        .flush (pipe_flush),
        .d     (d_bundle),
        .q     (e_bundle)
    );

    // State sequencing; LDSTALL always leaves after one cycle because E then
    // holds a bubble, so no load-use can be seen from it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN, LDSTALL, MEMWAIT: begin
                    if (MemBusy)       state <= MEMWAIT;
                    else if (PCSrcE)   state <= RUN;
                    else if (load_use) state <= LDSTALL;
                    else               state <= RUN;
                end
                default: state <= BOOT;
            endcase
        end
    end

    // Branch flush counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt <= '0;
        end else if (take_branch && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign BranchE   = e_bundle.branch;
    assign MemWriteE = e_bundle.mem_write;
    assign RegWriteE = e_bundle.reg_write;
    assign FlagWE    = e_bundle.flag_w;
    assign NoWriteE  = e_bundle.no_write;
    assign MemtoRegE = e_bundle.mem_to_reg;
    assign CondE     = e_bundle.cond;
    assign WA3E      = e_bundle.wa3[RAW-1:0];
    assign ValidE    = e_bundle.valid;
    assign FlushCnt  = flush_cnt;

endmodule

// File: tb/tb_exec_ctrl_issue.sv
// Scoreboard bench for exec_ctrl_issue: a stimulus process drives one
// decode bundle per cycle and queues the expected response from a simple
// slot-level model; a monitor process pops and compares every cycle.
module tb_exec_ctrl_issue;

    localparam int RAW     = 4;
    localparam int CNTW    = 2;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ValidD = 0, BranchD = 0, MemWriteD = 0, RegWriteD = 0;
    logic FlagWD = 0, NoWriteD = 0, MemtoRegD = 0;
    logic [1:0] CondD = '0;
    logic [RAW-1:0] RA1D = '0, RA2D = '0, WA3D = '0;
    logic PCSrcE = 0, MemBusy = 0;
    logic BranchE, MemWriteE, RegWriteE, FlagWE, NoWriteE, MemtoRegE;
    logic [1:0] CondE;
    logic [RAW-1:0] WA3E;
    logic ValidE, StallF, StallD, FlushD;
    logic [CNTW-1:0] FlushCnt;

    exec_ctrl_issue #(.RAW(RAW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .ValidD(ValidD), .BranchD(BranchD),
        .MemWriteD(MemWriteD), .RegWriteD(RegWriteD), .FlagWD(FlagWD),
        .NoWriteD(NoWriteD), .MemtoRegD(MemtoRegD), .CondD(CondD),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D), .PCSrcE(PCSrcE),
        .MemBusy(MemBusy), .BranchE(BranchE), .MemWriteE(MemWriteE),
        .RegWriteE(RegWriteE), .FlagWE(FlagWE), .NoWriteE(NoWriteE),
        .MemtoRegE(MemtoRegE), .CondE(CondE), .WA3E(WA3E), .ValidE(ValidE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic br, mw, rw, fw, nw, m2r;
        logic [1:0] cond;
        logic [RAW-1:0] wa3;
        logic valid;
    } slot_t;

    typedef struct packed {
        logic membusy, pcsrc, valid, br, mw, rw, fw, nw, m2r;
        logic [1:0] cond;
        logic [RAW-1:0] ra1, ra2, wa3;
    } stim_t;

    typedef struct packed {
        logic stallf, stalld, flushd;
        slot_t e;
        logic [CNTW-1:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_x;
    slot_t e_act;
    assign e_act = {BranchE, MemWriteE, RegWriteE, FlagWE, NoWriteE, MemtoRegE, CondE, WA3E, ValidE};

    // Reference model: what sits in the execute slot, whether the front end
    // is still booting, and how many branch flushes have happened.
    slot_t m_e     = '0;
    bit    m_boot  = 1'b0;
    int    m_flush = 0;

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    // Drive one decode cycle and queue what the DUT should show during it.
    task automatic step(input stim_t s);
        exp_t  x;
        slot_t nxt;
        bit    dep;
        @(negedge clk);
        MemBusy = s.membusy; PCSrcE = s.pcsrc; ValidD = s.valid;
        BranchD = s.br; MemWriteD = s.mw; RegWriteD = s.rw; FlagWD = s.fw;
        NoWriteD = s.nw; MemtoRegD = s.m2r; CondD = s.cond;
        RA1D = s.ra1; RA2D = s.ra2; WA3D = s.wa3;
        x.e   = m_e;
        x.cnt = CNTW'(m_flush);
        if (m_boot) begin
            {x.stallf, x.stalld, x.flushd} = 3'b001;
            nxt    = '0;
            m_boot = 1'b0;
        end else if (s.membusy) begin
            {x.stallf, x.stalld, x.flushd} = 3'b110;
            nxt = m_e;
        end else begin
            dep = m_e.m2r && m_e.valid && s.valid && (m_e.wa3 == s.ra1 || m_e.wa3 == s.ra2);
            if (s.pcsrc) begin
                {x.stallf, x.stalld, x.flushd} = 3'b001;
                nxt = '0;
                if (m_flush < CNT_MAX) m_flush = m_flush + 1;
            end else if (dep) begin
                {x.stallf, x.stalld, x.flushd} = 3'b110;
                nxt = '0;
            end else begin
                {x.stallf, x.stalld, x.flushd} = 3'b000;
                nxt = s.valid ? {s.br, s.mw, s.rw, s.fw, s.nw, s.m2r, s.cond, s.wa3, 1'b1} : '0;
            end
        end
        exp_q.push_back(x);
        m_e = nxt;
    endtask

    // Short reset pulse inside one low clock phase; the remainder of that
    // cycle is the BOOT cycle, whose edge loads a bubble.
    task automatic partial_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if (e_act !== '0 || FlushCnt !== '0) begin
            n_bad++;
            $display("FAIL rst_async: E=%h cnt=%0d, required E=0 cnt=0", e_act, FlushCnt);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({StallF, StallD, FlushD} !== 3'b001) begin
            n_bad++;
            $display("FAIL rst_boot: stallF/stallD/flushD=%b, required 001", {StallF, StallD, FlushD});
        end
        m_e     = '0;
        m_boot  = 1'b0;
        m_flush = 0;
    endtask

    // Monitor: compare the queued expectation just before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (exp_q.size() > 0) begin
                mon_x = exp_q.pop_front();
                n_txn++;
                n_cmp++;
                if ({StallF, StallD, FlushD} !== {mon_x.stallf, mon_x.stalld, mon_x.flushd}) begin
                    n_bad++;
                    $display("FAIL ctrl txn %0d: stallF/stallD/flushD=%b, required %b", n_txn,
                             {StallF, StallD, FlushD}, {mon_x.stallf, mon_x.stalld, mon_x.flushd});
                end
                n_cmp++;
                if (e_act !== mon_x.e) begin
                    n_bad++;
                    $display("FAIL e_slot txn %0d: E=%h, required %h", n_txn, e_act, mon_x.e);
                end
                n_cmp++;
                if (FlushCnt !== mon_x.cnt) begin
                    n_bad++;
                    $display("FAIL flush_cnt txn %0d: cnt=%0d, required %0d", n_txn, FlushCnt, mon_x.cnt);
                end
                $display("txn %0d: stall=%b%b flushD=%b E=%h valid=%b cnt=%0d", n_txn,
                         StallF, StallD, FlushD, e_act, ValidE, FlushCnt);
            end
        end
    end

    initial begin
        stim_t s;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (e_act !== '0 || FlushCnt !== '0 || FlushD !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: E=%h cnt=%0d flushD=%b, required 0/0/1", e_act, FlushCnt, FlushD);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        m_boot = 1'b1;

        // First instruction after reset: BOOT cycle flushes, then it issues.
        s = '0; s.valid = 1; s.rw = 1; s.wa3 = 4'd3;
        step(s); step(s);
        // Load to r5 followed by a dependent instruction.
        s = '0; s.valid = 1; s.m2r = 1; s.rw = 1; s.wa3 = 4'd5;
        step(s);
        s = '0; s.valid = 1; s.rw = 1; s.ra1 = 4'd5; s.wa3 = 4'd6;
        step(s); step(s); step(s);
        // Five taken branches against a 2-bit counter.
        s.pcsrc = 1;
        repeat (5) step(s);
        // Store in E while memory is busy for three cycles.
        s = '0; s.valid = 1; s.mw = 1; s.wa3 = 4'd2;
        step(s);
        s.membusy = 1; s.mw = 0; s.wa3 = 4'd1;
        repeat (3) step(s);
        s.membusy = 0;
        step(s); step(s);
        // Branch and load-use together resolve as a flush only.
        s = '0; s.valid = 1; s.m2r = 1; s.wa3 = 4'd7;
        step(s);
        s = '0; s.valid = 1; s.ra2 = 4'd7; s.pcsrc = 1;
        step(s);
        s.pcsrc = 0;
        step(s);
        // Reset pulse while in the load-use stall cycle.
        s = '0; s.valid = 1; s.m2r = 1; s.wa3 = 4'd9;
        step(s);
        s = '0; s.valid = 1; s.rw = 1; s.ra1 = 4'd9; s.wa3 = 4'd4;
        step(s);
        partial_reset();
        step(s); step(s);

        // Randomized traffic with load-use biased towards the slot's target.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                partial_reset();
            end else begin
                s.membusy = ($urandom_range(0, 99) < 15);
                s.pcsrc   = ($urandom_range(0, 99) < 15);
                s.valid   = ($urandom_range(0, 99) < 85);
                s.br      = 1'($urandom);
                s.mw      = 1'($urandom);
                s.rw      = 1'($urandom);
                s.fw      = 1'($urandom);
                s.nw      = 1'($urandom);
                s.m2r     = ($urandom_range(0, 99) < 40);
                s.cond    = 2'($urandom);
                s.ra1     = ($urandom_range(0, 1) == 0) ? m_e.wa3 : RAW'($urandom);
                s.ra2     = RAW'($urandom);
                s.wa3     = RAW'($urandom);
                step(s);
            end
        end

        @(negedge clk);
        #6;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
